// File: rtl/switch_conditioner_pkg.sv
// Shared types and constants for the switch conditioner
// and the board-level clocking logic.
package switch_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } state_e;

  localparam logic PRESSED_LVL = 1'b1;

  localparam int unsigned BOARD_CLK_HZ = 12000000;

  // Counter width for a count up to n, never zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Conditioned switch outputs bundle: the conditioner drives
// it (master), consumer logic reads it (slave).
interface switch_conditioner_if;

  logic       SW_LEVEL;
  logic       PRESS_PULSE;
  logic       RELEASE_PULSE;
  logic       LONG_PULSE;
  logic       HELD_LONG;
  logic [7:0] PRESS_COUNT;

  modport master (
    output SW_LEVEL,
    output PRESS_PULSE,
    output RELEASE_PULSE,
    output LONG_PULSE,
    output HELD_LONG,
    output PRESS_COUNT
  );

  modport slave (
    input SW_LEVEL,
    input PRESS_PULSE,
    input RELEASE_PULSE,
    input LONG_PULSE,
    input HELD_LONG,
    input PRESS_COUNT
  );

endinterface

// File: rtl/switch_conditioner_sync.sv
// Multi-flop synchroniser for the raw asynchronous pin,
// reset to a caller-chosen idle level.
module switch_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // shift the pin in at bit 0
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // flop chain, loads the idle level on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {STAGES{rst_val_i}};
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/switch_conditioner.sv
// Push-button conditioner: sync, debounce, press/release
// pulses, long-press detect and a wrapping press count.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLK_12MHz,
  input  logic RST,
  input  logic MYSWITCH,
  switch_conditioner_if.master sw
);

  localparam int unsigned DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned LW = cnt_w(LONG_CYCLES);
  // The sample that leaves IDLE/PRESSED/LONG_HELD is the
  // first stable one, so the wait states need D-1 more.
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
  localparam logic REL_RAW = ACTIVE_LOW ? PRESSED_LVL
                                        : ~PRESSED_LVL;

  logic sync_raw;
  logic s;

  state_e        state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          longf_q, longf_d;

  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;
  logic       long_q, long_d;
  logic       held_q, held_d;
  logic [7:0] count_q, count_d;

  switch_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i     (CLK_12MHz),
    .rst_i     (RST),
    .rst_val_i (REL_RAW),
    .d_i       (MYSWITCH),
    .q_o       (sync_raw)
  );

  assign s = ACTIVE_LOW ? ~sync_raw : sync_raw;

  // state, counters and registered outputs
  always_ff @(posedge CLK_12MHz) begin
    if (RST) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
      longf_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
      longf_q <= longf_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      held_q  <= held_d;
      count_q <= count_d;
    end
  end

  // next state and counter updates
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    lcnt_d  = lcnt_q;
    longf_d = longf_q;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (dcnt_q == D_LAST) begin
          state_d = PRESSED;
          lcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
          longf_d = 1'b0;
        end else if (lcnt_q == L_LAST) begin
          state_d = LONG_HELD;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
          longf_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          if (longf_q || lcnt_q == L_LAST) begin
            state_d = LONG_HELD;
          end else begin
            state_d = PRESSED;
            lcnt_d  = lcnt_q + 1'b1;
          end
        end else if (dcnt_q == D_LAST) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output next values, one pulse per transition
  always_comb begin
    press_d = (state_q == PRESS_WAIT) && s &&
              (dcnt_q == D_LAST);
    rel_d   = (state_q == RELEASE_WAIT) && !s &&
              (dcnt_q == D_LAST);
    long_d  = s && (lcnt_q == L_LAST) &&
              ((state_q == PRESSED) ||
               ((state_q == RELEASE_WAIT) && !longf_q));
    level_d = press_d ? 1'b1 : (rel_d ? 1'b0 : level_q);
    held_d  = long_d ? 1'b1 : (rel_d ? 1'b0 : held_q);
    count_d = count_q + {7'd0, press_d};
  end

  assign sw.SW_LEVEL      = level_q;
  assign sw.PRESS_PULSE   = press_q;
  assign sw.RELEASE_PULSE = rel_q;
  assign sw.LONG_PULSE    = long_q;
  assign sw.HELD_LONG     = held_q;
  assign sw.PRESS_COUNT   = count_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: run-length reference model,
// vector table, directed corner sequences and random pin.
module tb_switch_conditioner;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw = 1'b1;

  always #5 clk = ~clk;

  switch_conditioner_if sw_if ();

  switch_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .CLK_12MHz (clk),
    .RST       (rst),
    .MYSWITCH  (raw),
    .sw        (sw_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // reference model state: pin history, run length of the
  // pressed/released value seen, hold-sample count
  bit       h0 = 1'b1, h1 = 1'b1, prev_s = 1'b0;
  int       run = 0, lc = 0;
  bit       m_level = 0, m_press = 0, m_rel = 0;
  bit       m_long = 0, m_held = 0;
  logic [7:0] m_count = 8'd0;

  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press = -1, last_rel = -1, last_long = -1;
  bit rel_held = 0, rel_level = 0;

  // model: a level change is accepted after D equal samples;
  // a long press after L pressed samples past acceptance
  always @(posedge clk) begin : model
    bit s, lv, pp, rp, lp, hd;
    int r, lcv;
    logic [7:0] ct;
    cyc <= cyc + 1;
    if (rst) begin
      h0 <= 1'b1; h1 <= 1'b1; prev_s <= 1'b0;
      run <= 0; lc <= 0;
      m_level <= 0; m_press <= 0; m_rel <= 0;
      m_long <= 0; m_held <= 0; m_count <= 8'd0;
    end else begin
      s = ~h1;
      r = (s == prev_s) ? run + 1 : 1;
      lv = m_level; hd = m_held; lcv = lc; ct = m_count;
      pp = 0; rp = 0; lp = 0;
      if (!lv && s && r >= D) begin
        lv = 1; pp = 1; ct = ct + 8'd1; lcv = 0;
      end else if (lv && !s && r >= D) begin
        lv = 0; rp = 1; hd = 0;
      end else if (lv && s && !hd) begin
        lcv = lcv + 1;
        if (lcv == L) begin lp = 1; hd = 1; end
      end
      h1 <= h0; h0 <= raw; prev_s <= s; run <= r;
      lc <= lcv; m_level <= lv; m_press <= pp;
      m_rel <= rp; m_long <= lp; m_held <= hd;
      m_count <= ct;
    end
  end

  task automatic check(input string nm, input int got,
                       input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d",
               nm, got, exp, cyc);
    end
  endtask

  // one cycle: advance to just after the falling edge,
  // log pulses and compare against the model
  task automatic step();
    logic [12:0] got, exp;
    @(negedge clk);
    #1;
    if (sw_if.PRESS_PULSE === 1'b1) begin
      n_press++; last_press = cyc;
    end
    if (sw_if.RELEASE_PULSE === 1'b1) begin
      n_rel++; last_rel = cyc;
      rel_held = sw_if.HELD_LONG;
      rel_level = sw_if.SW_LEVEL;
    end
    if (sw_if.LONG_PULSE === 1'b1) begin
      n_long++; last_long = cyc;
    end
    if (chk_en) begin
      got = {sw_if.SW_LEVEL, sw_if.PRESS_PULSE,
             sw_if.RELEASE_PULSE, sw_if.LONG_PULSE,
             sw_if.HELD_LONG, sw_if.PRESS_COUNT};
      exp = {m_level, m_press, m_rel, m_long, m_held,
             m_count};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model cyc=%0d got=%h exp=%h",
                 cyc, got, exp);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic int cnt_of(input int which);
    if (which == 0) return n_press;
    if (which == 1) return n_rel;
    return n_long;
  endfunction

  // bounded wait for the next pulse of the given kind
  task automatic wait_pulse(input int which, input int lim,
                            input string nm);
    int n0, k;
    n0 = cnt_of(which);
    k = 0;
    while (cnt_of(which) == n0 && k < lim) begin
      step(); k++;
    end
    if (cnt_of(which) == n0) begin
      checks++; errors++;
      $display("FAIL %s timeout got=none exp=pulse", nm);
    end
  endtask

  typedef struct {
    int low;
    int high;
    int e_press;
    int e_rel;
    int e_long;
  } vec_t;

  vec_t vt[6];

  initial begin
    int t, p, r, c0, np0, nr0, nl0;
    vt[0] = '{1, 10, 0, 0, 0};
    vt[1] = '{3, 10, 0, 0, 0};
    vt[2] = '{4, 10, 1, 1, 0};
    vt[3] = '{13, 10, 1, 1, 0};
    vt[4] = '{14, 10, 1, 1, 1};
    vt[5] = '{30, 10, 1, 1, 1};

    // reset with the pin released
    rst = 1'b1; raw = 1'b1;
    steps(5);
    check("rst_level", sw_if.SW_LEVEL, 0);
    check("rst_count", sw_if.PRESS_COUNT, 0);
    check("rst_pulses", sw_if.PRESS_PULSE |
          sw_if.RELEASE_PULSE | sw_if.LONG_PULSE |
          sw_if.HELD_LONG, 0);
    rst = 1'b0; chk_en = 1'b1;
    steps(10);
    check("idle_pulses", n_press + n_rel + n_long, 0);

    // clean press held 30 cycles, then release
    raw = 1'b0; t = cyc;
    wait_pulse(0, 20, "press");
    check("press_lat", last_press, t + 6);
    check("press_level", sw_if.SW_LEVEL, 1);
    check("press_count", sw_if.PRESS_COUNT, 1);
    steps(30 - (cyc - t));
    check("long_lat", last_long - last_press, 10);
    check("held_long", sw_if.HELD_LONG, 1);
    check("press_once", n_press, 1);
    raw = 1'b1; r = cyc;
    wait_pulse(1, 20, "release");
    check("rel_lat", last_rel, r + 6);
    check("rel_held", rel_held, 0);
    check("rel_level", rel_level, 0);
    steps(8);

    // short low glitches are rejected
    np0 = n_press; c0 = sw_if.PRESS_COUNT;
    for (int g = 0; g < 5; g++) begin
      raw = 1'b0; steps(3);
      raw = 1'b1; steps(3);
    end
    steps(10);
    check("glitch_press", n_press, np0);
    check("glitch_level", sw_if.SW_LEVEL, 0);
    check("glitch_count", sw_if.PRESS_COUNT, c0);

    // release bounce while pressed freezes the long count
    np0 = n_press; nr0 = n_rel;
    raw = 1'b0;
    wait_pulse(0, 20, "press2");
    p = last_press;
    steps(3);
    raw = 1'b1; steps(2);
    raw = 1'b0;
    wait_pulse(2, 40, "long2");
    check("bounce_long", last_long - p, 12);
    check("bounce_rel", n_rel, nr0);
    check("bounce_press", n_press, np0 + 1);
    raw = 1'b1; steps(12);

    // 256 presses wrap the counter
    np0 = n_press; c0 = sw_if.PRESS_COUNT;
    for (int i = 0; i < 256; i++) begin
      raw = 1'b0; steps(7);
      raw = 1'b1; steps(7);
    end
    check("wrap_n", n_press - np0, 256);
    check("wrap_count", sw_if.PRESS_COUNT, c0);

    // reset during debounce, switch held through it
    steps(5);
    np0 = n_press;
    raw = 1'b0; steps(4);
    rst = 1'b1; steps(2);
    check("rstpw_press", n_press, np0);
    check("rstpw_count", sw_if.PRESS_COUNT, 0);
    rst = 1'b0; r = cyc;
    wait_pulse(0, 20, "rst_press");
    check("rst_press_lat", last_press, r + 6);
    check("rst_press_cnt", sw_if.PRESS_COUNT, 1);
    raw = 1'b1; steps(12);

    // vector table: low then high window, pulse tallies
    foreach (vt[i]) begin
      np0 = n_press; nr0 = n_rel; nl0 = n_long;
      raw = 1'b0; steps(vt[i].low);
      raw = 1'b1; steps(vt[i].high);
      check($sformatf("vec%0d_press", i),
            n_press - np0, vt[i].e_press);
      check($sformatf("vec%0d_rel", i),
            n_rel - nr0, vt[i].e_rel);
      check($sformatf("vec%0d_long", i),
            n_long - nl0, vt[i].e_long);
    end

    // random pin activity with occasional resets
    for (int i = 0; i < 400; i++) begin
      raw = ~raw;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        steps($urandom_range(1, 3));
        rst = 1'b0;
      end
      steps($urandom_range(1, 18));
    end
    raw = 1'b1; steps(12);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
